// File: rtl/prim_ram_initiator.sv
// Request/response front end for a single-port RAM with an in-order response buffer.
// Optional address range checking is enabled by defining PRIM_RAM_INITIATOR_ADDR_CHECK_EN.
module prim_ram_initiator #(
  parameter int unsigned Width    = 32,
  parameter int unsigned Depth    = 128,
  parameter int unsigned RspDepth = 2,
  parameter int unsigned Aw       = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_write_i,
  input  logic [Aw-1:0]    req_addr_i,
  input  logic [Width-1:0] req_wdata_i,
  input  logic [Width-1:0] req_wmask_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [Width-1:0] rsp_rdata_o,
  output logic             rsp_err_o,
  output logic             ram_req_o,
  output logic             ram_write_o,
  output logic [Aw-1:0]    ram_addr_o,
  output logic [Width-1:0] ram_wdata_o,
  output logic [Width-1:0] ram_wmask_o,
  input  logic [Width-1:0] ram_rdata_i
);

  localparam int unsigned PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam int unsigned CntW = $clog2(RspDepth + 1);

  typedef struct packed {
    logic             err;
    logic [Width-1:0] rdata;
  } rsp_t;

  rsp_t            rsp_mem_q [RspDepth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q;
  logic            inflight_q, pend_write_q, pend_err_q;

  logic            err_c, accept_c, push_c, pop_c;
  logic [CntW:0]   occ_c, limit_c;
  rsp_t            push_entry_c, head_c;

  function automatic logic [PtrW-1:0] inc_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(RspDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Out-of-range detection; when disabled every address goes to the RAM.
  always_comb begin
    err_c = 1'b0;
`ifdef PRIM_RAM_INITIATOR_ADDR_CHECK_EN
    err_c = 32'(req_addr_i) >= 32'(Depth);
`endif
  end

  // Accept only while the buffer can absorb everything already committed.
  always_comb begin
    pop_c       = rsp_valid_o & rsp_ready_i;
    occ_c       = (CntW+1)'(cnt_q) + (CntW+1)'(inflight_q);
    limit_c     = (CntW+1)'(RspDepth) + (CntW+1)'(pop_c);
    req_ready_o = occ_c < limit_c;
    accept_c    = req_valid_i & req_ready_o;
    push_c      = inflight_q;
  end

  always_comb begin
    ram_req_o   = accept_c & ~err_c;
    ram_write_o = req_write_i;
    ram_addr_o  = req_addr_i;
    ram_wdata_o = req_wdata_i;
    ram_wmask_o = req_wmask_i;
  end

  // Entry captured one cycle after acceptance, when RAM read data is valid.
  always_comb begin
    push_entry_c = '0;
    if (pend_err_q) begin
      push_entry_c.err = 1'b1;
    end else if (!pend_write_q) begin
      push_entry_c.rdata = ram_rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q   <= 1'b0;
      pend_write_q <= 1'b0;
      pend_err_q   <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
    end else begin
      inflight_q   <= accept_c;
      pend_write_q <= req_write_i;
      pend_err_q   <= err_c;
      if (push_c) wptr_q <= inc_ptr(wptr_q);
      if (pop_c)  rptr_q <= inc_ptr(rptr_q);
      cnt_q        <= cnt_q + CntW'(push_c) - CntW'(pop_c);
    end
  end

  // Storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (push_c) rsp_mem_q[wptr_q] <= push_entry_c;
  end

  always_comb begin
    head_c      = rsp_mem_q[rptr_q];
    rsp_valid_o = cnt_q != '0;
    rsp_rdata_o = rsp_valid_o ? head_c.rdata : '0;
    rsp_err_o   = rsp_valid_o & head_c.err;
  end

endmodule
